apb_vgachargen_if: RTL and testbench



---
 rtl/apb_vgachargen_if_if.sv | 22 ++
 rtl/apb_vgachargen_if.sv | 166 ++++++++++++++++
 tb/tb_apb_vgachargen_if.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_vgachargen_if_if.sv
// APB3/APB4 bus bundle between a bus master and the character-generator bridge.
interface apb_vgachargen_if_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_vgachargen_if.sv
// APB slave bridge onto the char-map, colour-map and glyph-table system ports.
// Byte strobes honoured only when APB_VGACHARGEN_PSTRB_EN is defined; otherwise every write is a full word.
module apb_vgachargen_if #(
  parameter int CH_MAP_ADDR_WIDTH = 12,
  parameter int CH_MAP_DATA_WIDTH = 8,
  parameter int CH_T_ADDR_WIDTH   = 7,
  parameter int CH_T_DATA_WIDTH   = 128
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  apb_vgachargen_if_if.slave           apb,
  output logic [CH_MAP_ADDR_WIDTH-1:0] ch_map_addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0] ch_map_data_o,
  output logic                         ch_map_wen_o,
  input  logic [CH_MAP_DATA_WIDTH-1:0] ch_map_data_i,
  output logic [CH_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
  output logic [7:0]                   col_map_data_o,
  output logic                         col_map_wen_o,
  input  logic [7:0]                   col_map_data_i,
  output logic [CH_T_ADDR_WIDTH-1:0]   ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0]   ch_t_rw_data_o,
  output logic                         ch_t_rw_wen_o,
  input  logic [CH_T_DATA_WIDTH-1:0]   ch_t_rw_data_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD1, S_RD2, S_RMW_RD, S_RMW_CAP, S_RMW_WR, S_RESP
  } state_e;

  typedef enum logic [1:0] {
    RGN_MAP = 2'b00,
    RGN_COL = 2'b01,
    RGN_GLY = 2'b10,
    RGN_BAD = 2'b11
  } region_e;

  state_e                     state_q,  state_d;
  region_e                    region_q, region_d;
  logic [13:2]                addr_q,   addr_d;
  logic [31:0]                wdata_q,  wdata_d;
  logic [3:0]                 strb_q,   strb_d;
  logic                       err_q,    err_d;
  logic [31:0]                prdata_q, prdata_d;
  logic [CH_T_DATA_WIDTH-1:0] merge_q,  merge_d;

  logic [3:0] strb_in;
  logic [1:0] word;
  logic       active;
  logic       setup;

`ifdef APB_VGACHARGEN_PSTRB_EN
  assign strb_in = apb.pstrb;
`else
  logic unused_pstrb;
  assign strb_in      = 4'hF;
  assign unused_pstrb = ^apb.pstrb;
`endif

  assign word   = addr_q[3:2];
  assign active = (state_q != S_IDLE);
  assign setup  = apb.psel && !apb.penable;

  always_comb begin
    // NOTE: every next-state value takes its hold value first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    region_d = region_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    merge_d  = merge_q;

    case (state_q)
      S_IDLE: begin
        if (setup) begin
          region_d = region_e'(apb.paddr[15:14]);
          addr_d   = apb.paddr[13:2];
          wdata_d  = apb.pwdata;
          strb_d   = strb_in;
          err_d    = (apb.paddr[15:14] == 2'b11) || (apb.paddr[1:0] != 2'b00);
          if (err_d) begin
            // Error transfers return zero, so the capture register is cleared here.
            prdata_d = '0;
            state_d  = S_RESP;
          end else if (!apb.pwrite) begin
            state_d = S_RD1;
          end else if (apb.paddr[15:14] == 2'b10) begin
            state_d = S_RMW_RD;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_WR:     state_d = S_RESP;
      S_RD1:    state_d = S_RD2;
      S_RD2: begin
        case (region_q)
          RGN_MAP: prdata_d = 32'(ch_map_data_i);
          RGN_COL: prdata_d = 32'(col_map_data_i);
          RGN_GLY: prdata_d = ch_t_rw_data_i[32*int'(word) +: 32];
          default: prdata_d = '0;
        endcase
        state_d = S_RESP;
      end
      S_RMW_RD: state_d = S_RMW_CAP;
      S_RMW_CAP: begin
        merge_d = ch_t_rw_data_i;
        for (int b = 0; b < 4; b++) begin
          if (strb_q[b]) merge_d[32*int'(word) + 8*b +: 8] = wdata_q[8*b +: 8];
        end
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge like any other input.
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      region_q <= RGN_MAP;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      merge_q  <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      merge_q  <= merge_d;
    end
  end

  // Addresses follow the latched transfer while busy and rest at zero when idle.
  assign ch_map_addr_o  = active ? addr_q[2 +: CH_MAP_ADDR_WIDTH] : '0;
  assign col_map_addr_o = active ? addr_q[2 +: CH_MAP_ADDR_WIDTH] : '0;
  assign ch_t_rw_addr_o = active ? addr_q[4 +: CH_T_ADDR_WIDTH]   : '0;

  assign ch_map_data_o  = active ? wdata_q[CH_MAP_DATA_WIDTH-1:0] : '0;
  assign col_map_data_o = active ? wdata_q[7:0] : '0;
  assign ch_t_rw_data_o = merge_q;

  assign ch_map_wen_o  = (state_q == S_WR) && (region_q == RGN_MAP) && strb_q[0];
  assign col_map_wen_o = (state_q == S_WR) && (region_q == RGN_COL) && strb_q[0];
  assign ch_t_rw_wen_o = (state_q == S_RMW_WR);

  assign apb.pready  = (state_q == S_RESP);
  assign apb.pslverr = (state_q == S_RESP) && err_q;
  assign apb.prdata  = prdata_q;

  a_wen_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0({ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o}));

  a_pready_single: assert property (@(posedge clk_i) disable iff (!rstn_i)
    apb.pready |=> !apb.pready);

endmodule

// File: tb/tb_apb_vgachargen_if.sv
// Directed bench for apb_vgachargen_if: transaction-level model with queued expectations and one compare process.
module tb_apb_vgachargen_if;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  apb_vgachargen_if_if apb();

  logic [11:0]  ch_map_addr,  col_map_addr;
  logic [7:0]   ch_map_wdata, col_map_wdata, ch_map_rdata, col_map_rdata;
  logic         ch_map_wen,   col_map_wen,   gly_wen;
  logic [6:0]   gly_addr;
  logic [127:0] gly_wdata, gly_rdata;

  apb_vgachargen_if dut (
    .clk_i(clk), .rstn_i(rstn), .apb(apb),
    .ch_map_addr_o(ch_map_addr),   .ch_map_data_o(ch_map_wdata),   .ch_map_wen_o(ch_map_wen),
    .ch_map_data_i(ch_map_rdata),
    .col_map_addr_o(col_map_addr), .col_map_data_o(col_map_wdata), .col_map_wen_o(col_map_wen),
    .col_map_data_i(col_map_rdata),
    .ch_t_rw_addr_o(gly_addr),     .ch_t_rw_data_o(gly_wdata),     .ch_t_rw_wen_o(gly_wen),
    .ch_t_rw_data_i(gly_rdata)
  );

  // Memories attached to the bridge: synchronous write, registered read.
  logic [7:0]   mem_map [4096];
  logic [7:0]   mem_col [4096];
  logic [127:0] mem_gly [128];
  always @(posedge clk) begin
    if (ch_map_wen)  mem_map[ch_map_addr] <= ch_map_wdata;
    if (col_map_wen) mem_col[col_map_addr] <= col_map_wdata;
    if (gly_wen)     mem_gly[gly_addr] <= gly_wdata;
    ch_map_rdata  <= mem_map[ch_map_addr];
    col_map_rdata <= mem_col[col_map_addr];
    gly_rdata     <= mem_gly[gly_addr];
  end

  // Reference contents and expectations derived from the address map.
  logic [7:0]   ref_map [4096];
  logic [7:0]   ref_col [4096];
  logic [127:0] ref_gly [128];

  typedef struct { int due; logic err; logic chk; logic [31:0] rdata; } resp_t;
  typedef struct { int tgt; int addr; logic [127:0] data; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  int mon_tgt  = -1;
  int mon_addr = -1;
  int mon_cnt  = 0;
  logic [127:0] mon_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string act, input string req);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=%s required=%s (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic model_xfer(input logic [15:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, input int t0);
    int rg, ent, g, wi;
    logic [3:0]  se;
    logic [31:0] m, old;
    resp_t r;
    wr_t   x;
    rg  = int'(a[15:14]);
    ent = int'(a[13:2]);
    g   = int'(a[10:4]);
    wi  = int'(a[3:2]);
`ifdef APB_VGACHARGEN_PSTRB_EN
    se = s;
`else
    se = 4'hF;
`endif
    r.err = 1'b0; r.chk = 1'b0; r.rdata = '0;
    if (rg == 3 || a[1:0] != 2'b00) begin
      r.due = t0 + 1; r.err = 1'b1; r.chk = 1'b1;
    end else if (w) begin
      if (rg == 2) begin
        m   = {{8{se[3]}}, {8{se[2]}}, {8{se[1]}}, {8{se[0]}}};
        old = ref_gly[g][wi*32 +: 32];
        ref_gly[g][wi*32 +: 32] = (old & ~m) | (d & m);
        x.tgt = 2; x.addr = g; x.data = ref_gly[g];
        wr_q.push_back(x);
        r.due = t0 + 4;
      end else begin
        if (se[0]) begin
          x.tgt = rg; x.addr = ent; x.data = 128'(d[7:0]);
          wr_q.push_back(x);
          if (rg == 0) ref_map[ent] = d[7:0];
          else         ref_col[ent] = d[7:0];
        end
        r.due = t0 + 2;
      end
    end else begin
      r.chk = 1'b1;
      r.due = t0 + 3;
      if (rg == 0)      r.rdata = 32'(ref_map[ent]);
      else if (rg == 1) r.rdata = 32'(ref_col[ent]);
      else              r.rdata = ref_gly[g][wi*32 +: 32];
    end
    resp_q.push_back(r);
  endtask

  // Single compare process: write pulses and responses against the queued expectations.
  always @(negedge clk) begin
    int    nw, tgt, adr;
    logic [127:0] dat;
    resp_t r;
    wr_t   e;
    if (mon_en) begin
      nw = int'(ch_map_wen) + int'(col_map_wen) + int'(gly_wen);
      if (nw != 0) begin
        check("wen_onehot", 128'(nw), 128'(1));
        tgt = gly_wen ? 2 : (col_map_wen ? 1 : 0);
        adr = gly_wen ? int'(gly_addr) : (col_map_wen ? int'(col_map_addr) : int'(ch_map_addr));
        dat = gly_wen ? gly_wdata : (col_map_wen ? 128'(col_map_wdata) : 128'(ch_map_wdata));
        mon_tgt = tgt; mon_addr = adr; mon_data = dat; mon_cnt++;
        if (wr_q.size() == 0) begin
          fail_now("unexpected_wen", $sformatf("wen target %0d", tgt), "no write");
        end else begin
          e = wr_q.pop_front();
          check("wen_target", 128'(tgt), 128'(e.tgt));
          check("wen_addr",   128'(adr), 128'(e.addr));
          check("wen_data",   dat,       e.data);
        end
      end
      if (resp_q.size() != 0 && resp_q[0].due < cyc) begin
        r = resp_q.pop_front();
        fail_now("pready_missing", "no pready", $sformatf("pready at cycle %0d", r.due));
      end
      if (apb.pready) begin
        if (resp_q.size() == 0) begin
          fail_now("unexpected_pready", "pready high", "pready low");
        end else begin
          r = resp_q.pop_front();
          check("resp_cycle", 128'(cyc), 128'(r.due));
          check("resp_pslverr", 128'(apb.pslverr), 128'(r.err));
          if (r.chk) check("resp_prdata", 128'(apb.prdata), 128'(r.rdata));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Starts at posedge+1; returns at posedge+1 of the cycle after the response.
  task automatic apb_xfer(input logic [15:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic er,
                          output int lat, input bit drop = 1'b0);
    int t0;
    rd = '0; er = 1'b0; lat = -1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.paddr = a;
    apb.pwrite = w;  apb.pwdata = d;     apb.pstrb = s;
    t0 = cyc;
    model_xfer(a, w, d, s, t0);
    @(posedge clk); #1;
    if (drop) apb.psel = 1'b0;
    else      apb.penable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (apb.pready) begin
        lat = cyc - t0; rd = apb.prdata; er = apb.pslverr;
        break;
      end
    end
    if (lat < 0) fail_now("pready_timeout", "no pready in 12 cycles", "pready");
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] rd;
  logic        er;
  int          lat, wc0;

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0;  apb.pwdata = '0;    apb.pstrb = '0;
    rstn = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      mem_map[i] = 8'(i * 7 + 3);
      mem_col[i] = 8'(i) ^ 8'h3C;
      ref_map[i] = mem_map[i];
      ref_col[i] = mem_col[i];
    end
    for (int i = 0; i < 128; i++) begin
      for (int k = 0; k < 4; k++) mem_gly[i][32*k +: 32] = 32'hA000_0000 + 32'(i * 256 + k);
      if (i == 3) mem_gly[i] = '1;
      ref_gly[i] = mem_gly[i];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wens",    {ch_map_wen, col_map_wen, gly_wen}, 0);
    check("rst_pready",  {apb.pready, apb.pslverr}, 0);
    check("rst_prdata",  apb.prdata, 0);
    check("rst_addrs",   {ch_map_addr, col_map_addr, gly_addr}, 0);
    check("rst_wdata",   {ch_map_wdata, col_map_wdata, gly_wdata}, 0);
    @(posedge clk); #1;
    rstn = 1'b1; mon_en = 1'b1;
    idle(1);

    // Char-map write then read back.
    apb_xfer(16'h0010, 1'b1, 32'h0000_0041, 4'hF, rd, er, lat);
    check("map_wr_lat_lit",  128'(lat), 2);
    check("map_wen_tgt_lit", 128'(mon_tgt), 0);
    check("map_wen_addr_lit", 128'(mon_addr), 4);
    check("map_wen_data_lit", mon_data, 128'h41);
    idle(1);
    apb_xfer(16'h0010, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("map_rd_data_lit", rd, 32'h41);
    check("map_rd_lat_lit",  128'(lat), 3);

    // Colour-map write.
    wc0 = mon_cnt;
    apb_xfer(16'h4008, 1'b1, 32'h0000_00A5, 4'hF, rd, er, lat);
    check("col_slverr_lit",   128'(er), 0);
    check("col_wen_tgt_lit",  128'(mon_tgt), 1);
    check("col_wen_addr_lit", 128'(mon_addr), 2);
    check("col_wen_data_lit", mon_data, 128'hA5);
    check("col_wen_count",    128'(mon_cnt - wc0), 1);

    // Glyph read-modify-write into the all-ones glyph 3, word 1, low half-word strobed.
    apb_xfer(16'h8034, 1'b1, 32'h1234_5678, 4'b0011, rd, er, lat);
    check("gly_wr_lat_lit",  128'(lat), 4);
    check("gly_wen_addr_lit", 128'(mon_addr), 3);
`ifdef APB_VGACHARGEN_PSTRB_EN
    check("gly_wen_data_lit", mon_data, 128'hFFFFFFFF_FFFFFFFF_FFFF5678_FFFFFFFF);
`else
    check("gly_wen_data_lit", mon_data, 128'hFFFFFFFF_FFFFFFFF_12345678_FFFFFFFF);
`endif
    apb_xfer(16'h8034, 1'b0, 32'h0, 4'hF, rd, er, lat);
    apb_xfer(16'h8030, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("gly_w0_rd_lit", rd, 32'hFFFF_FFFF);

    // Error transfers: bad region, misaligned read, misaligned write.
    wc0 = mon_cnt;
    apb_xfer(16'hC000, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("err_region_lat_lit", 128'(lat), 1);
    check("err_region_slverr",  128'(er), 1);
    check("err_region_prdata",  rd, 0);
    apb_xfer(16'h0002, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("err_align_lat_lit",  128'(lat), 1);
    check("err_align_slverr",   128'(er), 1);
    apb_xfer(16'h4001, 1'b1, 32'h0000_00EE, 4'hF, rd, er, lat);
    check("err_no_wen", 128'(mon_cnt - wc0), 0);

    // Byte-0 strobe cleared on a char-map write.
    wc0 = mon_cnt;
    apb_xfer(16'h0020, 1'b1, 32'h0000_0099, 4'b1110, rd, er, lat);
`ifdef APB_VGACHARGEN_PSTRB_EN
    check("strb_wen_count", 128'(mon_cnt - wc0), 0);
`else
    check("strb_wen_count", 128'(mon_cnt - wc0), 1);
`endif
    apb_xfer(16'h0020, 1'b0, 32'h0, 4'hF, rd, er, lat);

    // Reset asserted while the glyph write sits in its capture cycle.
    wc0 = mon_cnt;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.paddr = 16'h8058;
    apb.pwrite = 1'b1; apb.pwdata = 32'hDEAD_BEEF; apb.pstrb = 4'hF;
    @(posedge clk); #1; apb.penable = 1'b1;
    @(posedge clk); #1; rstn = 1'b0;
    @(posedge clk); #1;
    check("rstmid_wens",   {ch_map_wen, col_map_wen, gly_wen}, 0);
    check("rstmid_resp",   {apb.pready, apb.pslverr}, 0);
    check("rstmid_prdata", apb.prdata, 0);
    check("rstmid_addrs",  {ch_map_addr, col_map_addr, gly_addr}, 0);
    check("rstmid_wdata",  gly_wdata, 0);
    apb.psel = 1'b0; apb.penable = 1'b0; rstn = 1'b1;
    idle(2);
    check("rstmid_no_wen", 128'(mon_cnt - wc0), 0);
    apb_xfer(16'h8058, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("rstmid_gly_lit", rd, 32'hA000_0502);

    // Aliased glyph address with psel dropped during the access phase.
    apb_xfer(16'h8834, 1'b1, 32'hCAFE_F00D, 4'hF, rd, er, lat, 1'b1);
    check("alias_wen_addr_lit", 128'(mon_addr), 3);
    idle(1);
    apb_xfer(16'h8034, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("alias_rd_lit", rd, 32'hCAFE_F00D);

    // Back-to-back transfers with no idle cycle.
    apb_xfer(16'h0000, 1'b1, 32'h0000_0077, 4'hF, rd, er, lat);
    apb_xfer(16'h4000, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("b2b_col_rd_lit", rd, 32'h3C);
    apb_xfer(16'h0000, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("b2b_map_rd_lit", rd, 32'h77);
    for (int i = 0; i < 4; i++) apb_xfer(16'h8070 + 16'(4 * i), 1'b0, 32'h0, 4'hF, rd, er, lat);
    apb_xfer(16'h7FFC, 1'b1, 32'h0000_005E, 4'hF, rd, er, lat);
    apb_xfer(16'h7FFC, 1'b0, 32'h0, 4'hF, rd, er, lat);
    apb_xfer(16'h3FFC, 1'b0, 32'h0, 4'hF, rd, er, lat);
    apb_xfer(16'hBFFC, 1'b0, 32'h0, 4'hF, rd, er, lat);

    idle(3);
    check("wr_q_drained",   128'(wr_q.size()), 0);
    check("resp_q_drained", 128'(resp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
